uwasic_onboarding_joanna: RTL and testbench
===========================================

# uwasic_onboarding_joanna

SPI-configurable 16-channel output controller with a shared 8-bit PWM generator, packaged as a TinyTapeout user tile. An external SPI controller writes five 8-bit control registers. These registers set, per output bit, whether the bit is off, statically high, or driven by the PWM waveform. Outputs leave on the tile's dedicated and bidirectional output pins.

## Interface
- No parameters. Timing constants are fixed: system clock 10 MHz, PWM prescale 13, PWM period 256 steps.
- clk  input  1  system clock, 10 MHz, rising-edge active.
- rst_n  input  1  asynchronous reset, active-high. Asserting it (rst_n=1) immediately clears all state; it is released synchronously in effect.
- ena  input  1  tile select; ignored.
- ui_in  input  8  [0]=SCLK, [1]=COPI, [2]=nCS (active-low chip select); [7:3] unused.
- uio_in  input  8  unused.
- uo_out  output  8  output channels 7..0.
- uio_out  output  8  output channels 15..8.
- uio_oe  output  8  constant 8'hFF (all bidirectional pins are outputs).

## Operation
- Registers (all 8-bit, reset 0x00):
  - 0x00 en_out[7:0]
  - 0x01 en_out[15:8]
  - 0x02 en_pwm[7:0]
  - 0x03 en_pwm[15:8]
  - 0x04 duty
- SPI peripheral:
  - Mode 0, MSB first; write-only.
  - SCLK, COPI and nCS each pass through a 2-flop synchronizer into clk; edges are detected on the synchronized signals.
  - Transaction frame:
    - Starts on nCS falling edge; bit counter and shift register cleared.
    - Each synchronized SCLK rising edge while nCS low shifts in COPI.
    - 16-bit frame: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
  - Commit on the nCS rising edge, only if exactly 16 bits were received, bit15=1 and address ≤ 0x04.
  - No commit, registers unchanged, for:
    - reads (bit15=0);
    - addresses 0x05–0x7F;
    - frames shorter or longer than 16 bits.
  - SCLK edges while nCS high are ignored.
- PWM generator:
  - Prescaler counts 0..12 and advances an 8-bit counter 0..255, which wraps.
  - Period = 13×256 clk = 3328 clk, about 3.005 kHz.
  - pwm = 1 when duty==0xFF; otherwise pwm = (counter < duty).
  - duty 0x00 gives constant low; duty 0x80 gives 50% high.
- Output mux, per channel i in 0..15:
  - en_out[i]=0 → 0.
  - en_out[i]=1, en_pwm[i]=0 → 1.
  - en_out[i]=1, en_pwm[i]=1 → pwm.
  - {uio_out, uo_out} = out[15:0].

## Timing
- Reset:
  - Registers, counters, synchronizers and SPI state are 0, and uo_out=uio_out=0x00 immediately on assertion.
  - uio_oe=0xFF at all times, including reset.
  - Reset mid-frame discards the partial frame.
- SPI input constraints:
  - SCLK high and low phases ≥ 3 clk each (SCLK ≤ ~1.6 MHz).
  - COPI stable around the SCLK rising edge.
  - nCS setup/hold to SCLK ≥ 3 clk.
- Write latency: the register update is visible on outputs ≤ 4 clk after the nCS rising edge at the pins.
- Register changes take effect on the next clk:
  - output-enable changes are immediate;
  - duty changes apply to the current counter value with no end-of-period buffering.
- Outputs are registered or combinational from registers only; there is no combinational path from ui_in.
- Back-to-back frames are allowed with nCS high ≥ 3 clk between them.

## Test plan
- Reset: rst_n=1 then 0 → uo_out=0x00, uio_out=0x00, uio_oe=0xFF.
- Static enable: write 0x00←0xF0, then 0x01←0xCC → uo_out=0xF0, uio_out=0xCC.
- Ignored frames, from the state above:
  - read frame 0x00_55 (bit15=0) → no change;
  - write to address 0x30 → no change;
  - 15-bit frame → no change.
- PWM 50%:
  - write en_out[7:0]=0x01, en_pwm[7:0]=0x01, duty=0x80;
  - uo_out[0] period = 3328 clk ±1 (~3 kHz) with high time 1664 clk.
- Duty extremes: duty=0x00 → uo_out[0] constant 0 over ≥2 periods; duty=0xFF → constant 1.
- Mixed channels: en_out[15:8]=0xFF, en_pwm[15:8]=0x0F, duty=0x40 → uio_out[7:4] constant 1; uio_out[3:0] 25% duty, 832 clk high per period.

Source files
------------

// File: rtl/uwasic_onboarding_joanna.sv
// SPI-configurable 16-channel output controller with a shared 8-bit PWM.
// An SPI mode-0 write-only peripheral loads five control registers that
// select, per output bit, off / static high / PWM-driven.
//
// Ports:
//   clk      system clock (10 MHz), rising edge
//   rst_n    asynchronous reset, active-high despite the name
//   ena      tile select (ignored)
//   ui_in    [0]=SCLK, [1]=COPI, [2]=nCS; [7:3] unused
//   uio_in   unused
//   uo_out   output channels 7..0
//   uio_out  output channels 15..8
//   uio_oe   constant 8'hFF
module uwasic_onboarding_joanna (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int unsigned FRAME_BITS   = 16;
   localparam int unsigned CNT_W        = 5;
   localparam int unsigned PRESCALE     = 13;
   localparam int unsigned PRESCALE_W   = 4;
   localparam int unsigned NUM_CH       = 16;
   localparam int unsigned LAST_ADDR    = 4;

   typedef enum logic [0:0] {
      SPI_IDLE = 1'b0,
      SPI_RECV = 1'b1
   } spi_state_t;

   // Unused tile inputs folded into one sink signal.
   logic unused_inputs;
   assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:3]};

   // Two-flop synchronizers plus previous-value flops for edge detection.
   logic [1:0] sclk_sync;
   logic [1:0] copi_sync;
   logic [1:0] ncs_sync;
   logic       sclk_prev;
   logic       ncs_prev;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         sclk_sync <= 2'b00;
         copi_sync <= 2'b00;
         ncs_sync  <= 2'b00;
         sclk_prev <= 1'b0;
         ncs_prev  <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[0], ui_in[0]};
         copi_sync <= {copi_sync[0], ui_in[1]};
         ncs_sync  <= {ncs_sync[0],  ui_in[2]};
         sclk_prev <= sclk_sync[1];
         ncs_prev  <= ncs_sync[1];
      end
   end

   logic sclk_rise_c;
   logic ncs_fall_c;
   logic ncs_rise_c;
   assign sclk_rise_c = sclk_sync[1] & ~sclk_prev;
   assign ncs_fall_c  = ~ncs_sync[1] & ncs_prev;
   assign ncs_rise_c  = ncs_sync[1] & ~ncs_prev;

   // SPI frame FSM: idle until nCS falls, receive until nCS rises.
   spi_state_t state_q;
   spi_state_t state_d;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state_q <= SPI_IDLE;
      else       state_q <= state_d;
   end

   logic [FRAME_BITS-1:0] shift_q;
   logic [CNT_W-1:0]      bit_cnt_q;
   logic                  commit_c;
   logic                  frame_ok_c;

   // Exactly 16 bits, write flag set, address within the register map.
   assign frame_ok_c = (bit_cnt_q == CNT_W'(FRAME_BITS)) && shift_q[15]
                       && (shift_q[14:8] <= 7'(LAST_ADDR));

   always_comb begin
      state_d  = state_q;
      commit_c = 1'b0;
      case (state_q)
         SPI_IDLE: begin
            if (ncs_fall_c) state_d = SPI_RECV;
         end
         SPI_RECV: begin
            if (ncs_rise_c) begin
               state_d  = SPI_IDLE;
               commit_c = frame_ok_c;
            end
         end
         default: state_d = SPI_IDLE;
      endcase
   end

   // Shift register and saturating bit counter; overlong frames stay > 16.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else if (ncs_fall_c) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else if (state_q == SPI_RECV && sclk_rise_c && !ncs_sync[1]) begin
         shift_q <= {shift_q[FRAME_BITS-2:0], copi_sync[1]};
         if (bit_cnt_q != '1) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
   end

   // Control registers.
   logic [NUM_CH-1:0] en_out_q;
   logic [NUM_CH-1:0] en_pwm_q;
   logic [7:0]        duty_q;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         en_out_q <= '0;
         en_pwm_q <= '0;
         duty_q   <= '0;
      end else if (commit_c) begin
         case (shift_q[10:8])
            3'd0:    en_out_q[7:0]  <= shift_q[7:0];
            3'd1:    en_out_q[15:8] <= shift_q[7:0];
            3'd2:    en_pwm_q[7:0]  <= shift_q[7:0];
            3'd3:    en_pwm_q[15:8] <= shift_q[7:0];
            3'd4:    duty_q         <= shift_q[7:0];
            default: ;
         endcase
      end
   end

   // PWM timebase: prescaler 0..12 advances a free-running 8-bit counter.
   logic [PRESCALE_W-1:0] prescale_q;
   logic [7:0]            pwm_cnt_q;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         prescale_q <= '0;
         pwm_cnt_q  <= '0;
      end else if (prescale_q == PRESCALE_W'(PRESCALE - 1)) begin
         prescale_q <= '0;
         pwm_cnt_q  <= pwm_cnt_q + 8'(1);
      end else begin
         prescale_q <= prescale_q + PRESCALE_W'(1);
      end
   end

   logic pwm_c;
   assign pwm_c = (duty_q == 8'hFF) || (pwm_cnt_q < duty_q);

   // Registered output mux.
   logic [NUM_CH-1:0] out_q;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) out_q <= '0;
      else       out_q <= en_out_q & (~en_pwm_q | {NUM_CH{pwm_c}});
   end

   assign uo_out  = out_q[7:0];
   assign uio_out = out_q[15:8];
   assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_uwasic_onboarding_joanna.sv
module tb_uwasic_onboarding_joanna;

   localparam int PERIOD_CLK = 3328;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference register file: plain values, updated by frame rules.
   logic [15:0] m_en_out;
   logic [15:0] m_en_pwm;
   logic [7:0]  m_duty;

   uwasic_onboarding_joanna dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
   endtask

   // Send the low n bits of vec MSB first, updating the model by the frame rules.
   task automatic spi_frame(input logic [16:0] vec, input int n);
      logic [15:0] w;
      ui_in[2] = 1'b0;
      wait_clk(4);
      for (int i = n - 1; i >= 0; i--) begin
         ui_in[1] = vec[i];
         wait_clk(4);
         ui_in[0] = 1'b1;
         wait_clk(4);
         ui_in[0] = 1'b0;
      end
      wait_clk(4);
      ui_in[2] = 1'b1;
      wait_clk(6);
      w = vec[15:0];
      if (n == 16 && w[15] && w[14:8] <= 7'd4) begin
         case (w[10:8])
            3'd0: m_en_out[7:0]  = w[7:0];
            3'd1: m_en_out[15:8] = w[7:0];
            3'd2: m_en_pwm[7:0]  = w[7:0];
            3'd3: m_en_pwm[15:8] = w[7:0];
            default: m_duty      = w[7:0];
         endcase
      end
   endtask

   task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
      spi_frame({1'b0, 1'b1, addr, data}, 16);
   endtask

   // Compare outputs with the model on every channel whose level is known now.
   task automatic chk_outputs(input string tag);
      logic [15:0] mask;
      logic [15:0] exp;
      logic        known;
      logic        lvl;
      known = (m_duty == 8'h00) || (m_duty == 8'hFF);
      lvl   = (m_duty == 8'hFF);
      mask  = known ? 16'hFFFF : ~m_en_pwm;
      exp   = m_en_out & (~m_en_pwm | {16{lvl}});
      @(negedge clk);
      chk(tag, {16'h0, {uio_out, uo_out} & mask}, {16'h0, exp & mask});
   endtask

   // Count cycles a channel of {uio_out,uo_out} is high over n cycles.
   task automatic count_high(input int ch, input int n, output int hi);
      logic [15:0] o;
      hi = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         o = {uio_out, uo_out};
         if (o[ch]) hi++;
      end
   endtask

   // Period and high time of uo_out[0], rise to rise, with a cycle budget.
   task automatic measure(output int per, output int hi, output bit ok);
      int t;
      logic p;
      ok = 1'b0; per = 0; hi = 0; t = 0;
      @(negedge clk); p = uo_out[0];
      while (!(uo_out[0] && !p) && t < 4 * PERIOD_CLK) begin
         p = uo_out[0]; @(negedge clk); t++;
      end
      if (t >= 4 * PERIOD_CLK) return;
      t = 0;
      do begin
         if (uo_out[0]) hi++;
         p = uo_out[0]; @(negedge clk); per++; t++;
      end while (!(uo_out[0] && !p) && t < 4 * PERIOD_CLK);
      ok = (t < 4 * PERIOD_CLK);
   endtask

   initial begin
      int per, hi, d;
      bit ok;
      logic [6:0]  addr;
      logic [7:0]  data;
      logic        rw;
      logic [16:0] vec;
      int          len, sel;

      ena = 1'b1; uio_in = 8'h00; ui_in = 8'b0000_0100;
      m_en_out = '0; m_en_pwm = '0; m_duty = '0;
      rst_n = 1'b1;
      wait_clk(3);
      @(negedge clk);
      chk("reset_uo", {24'h0, uo_out}, 32'h00);
      chk("reset_uio", {24'h0, uio_out}, 32'h00);
      chk("reset_oe", {24'h0, uio_oe}, 32'hFF);
      rst_n = 1'b0;
      wait_clk(5);
      @(negedge clk);
      chk("post_reset_uo", {24'h0, uo_out}, 32'h00);

      // Static enables.
      spi_write(7'h00, 8'hF0);
      spi_write(7'h01, 8'hCC);
      @(negedge clk);
      chk("static_uo", {24'h0, uo_out}, 32'hF0);
      chk("static_uio", {24'h0, uio_out}, 32'hCC);

      // Ignored frames.
      spi_frame({1'b0, 16'h0055}, 16);
      chk_outputs("ign_read");
      spi_frame({1'b0, 1'b1, 7'h30, 8'h12}, 16);
      chk_outputs("ign_addr");
      spi_frame({2'b00, 1'b1, 7'h00, 7'h00}, 15);
      chk_outputs("ign_short");
      spi_frame({1'b1, 7'h00, 8'h0F, 1'b1}, 17);
      chk_outputs("ign_long");
      @(negedge clk);
      chk("ign_final", {16'h0, uio_out, uo_out}, 32'hCCF0);

      // Randomized frames against the register model.
      for (int k = 0; k < 40; k++) begin
         sel  = $urandom_range(0, 9);
         addr = (sel < 7) ? 7'($urandom_range(0, 4)) : 7'($urandom_range(5, 127));
         rw   = ($urandom_range(0, 5) != 0);
         data = 8'($urandom);
         if (addr == 7'd4 && $urandom_range(0, 1) == 1)
            data = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
         sel = $urandom_range(0, 9);
         len = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
         if (len == 16)      vec = {1'b0, rw, addr, data};
         else if (len == 15) vec = {2'b00, rw, addr, data[7:1]};
         else                vec = {rw, addr, data, 1'($urandom)};
         spi_frame(vec, len);
         chk_outputs($sformatf("rand%0d", k));
      end

      // PWM 50%.
      spi_write(7'h01, 8'h00); spi_write(7'h03, 8'h00);
      spi_write(7'h00, 8'h01); spi_write(7'h02, 8'h01);
      spi_write(7'h04, 8'h80);
      measure(per, hi, ok);
      chk("pwm50_found", {31'h0, ok}, 32'h1);
      chk("pwm50_period", per, PERIOD_CLK);
      chk("pwm50_high", hi, 1664);

      // Duty extremes.
      spi_write(7'h04, 8'h00);
      count_high(0, 2 * PERIOD_CLK, hi);
      chk("duty00_high", hi, 0);
      spi_write(7'h04, 8'hFF);
      count_high(0, 2 * PERIOD_CLK, hi);
      chk("dutyFF_high", hi, 2 * PERIOD_CLK);

      // Random duty: high time per period is 13 * duty.
      for (int k = 0; k < 3; k++) begin
         d = $urandom_range(1, 254);
         spi_write(7'h04, 8'(d));
         count_high(0, PERIOD_CLK, hi);
         chk($sformatf("duty_rand%0d", k), hi, 13 * d);
      end

      // Mixed channels.
      spi_write(7'h01, 8'hFF); spi_write(7'h03, 8'h0F);
      spi_write(7'h04, 8'h40);
      count_high(15, PERIOD_CLK, hi);
      chk("mixed_static", hi, PERIOD_CLK);
      count_high(8, PERIOD_CLK, hi);
      chk("mixed_pwm", hi, 832);
      count_high(11, PERIOD_CLK, hi);
      chk("mixed_pwm_b3", hi, 832);

      // Reset mid-frame discards the partial frame and clears outputs at once.
      spi_write(7'h03, 8'h00);
      spi_write(7'h02, 8'h00);
      ui_in[2] = 1'b0;
      wait_clk(4);
      for (int i = 0; i < 8; i++) begin
         ui_in[1] = 1'b1; wait_clk(4); ui_in[0] = 1'b1; wait_clk(4); ui_in[0] = 1'b0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midreset_uo", {24'h0, uo_out}, 32'h00);
      chk("midreset_uio", {24'h0, uio_out}, 32'h00);
      chk("midreset_oe", {24'h0, uio_oe}, 32'hFF);
      m_en_out = '0; m_en_pwm = '0; m_duty = '0;
      wait_clk(3);
      rst_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ui_in[1] = 1'b1; wait_clk(4); ui_in[0] = 1'b1; wait_clk(4); ui_in[0] = 1'b0;
      end
      wait_clk(4);
      ui_in[2] = 1'b1;
      wait_clk(6);
      chk_outputs("midreset_after");
      spi_write(7'h00, 8'h5A);
      chk_outputs("after_reset_write");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
